// File: rtl/k423_pcu_sb.sv
// k423_pcu_sb: scoreboard pipeline control unit for the k423 core.
// Each architectural register holds a countdown of the cycles left before its
// in-flight result can be forwarded. The countdown drives load-use style
// hazard stalls, while MDU-busy stalls, WB-resolved flushes and a stall-cycle
// performance counter are handled alongside it.

`ifndef INST_RSDIDX_W
`define INST_RSDIDX_W 5
`endif

module k423_pcu_sb #(
  parameter  int NUM_SRC = 2,
  parameter  int MAX_LAT = 7,
  parameter  int CNT_W   = 32,
  localparam int LAT_W   = $clog2(MAX_LAT + 1),
  localparam int IDX_W   = `INST_RSDIDX_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     id_vld_i,
  input  logic [NUM_SRC-1:0]       id_rs_vld_i,
  input  logic [NUM_SRC*IDX_W-1:0] id_rs_idx_i,
  input  logic                     id_rd_vld_i,
  input  logic [IDX_W-1:0]         id_rd_idx_i,
  input  logic [LAT_W-1:0]         id_rd_lat_i,
  input  logic                     mdu_busy_i,
  input  logic                     wb_bju_upd_mis_i,
  input  logic                     wb_excp_br_tkn_i,
  output logic                     pcu_clear_pc_o,
  output logic                     pcu_clear_if_id_o,
  output logic                     pcu_clear_id_ex_o,
  output logic                     pcu_clear_ex_wb_o,
  output logic                     pcu_stall_pc_o,
  output logic                     pcu_stall_if_id_o,
  output logic                     pcu_stall_id_ex_o,
  output logic                     pcu_stall_ex_wb_o,
  output logic                     pcu_issue_o,
  output logic [CNT_W-1:0]         pcu_stall_cnt_o
);

  localparam int NREG = 1 << IDX_W;

  // Entry 0 only ever holds its reset value, so x0 never looks pending.
  logic [LAT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] stall_cnt_q;

  logic             branch;
  logic             hazard;
  logic             src_hit;
  logic [IDX_W-1:0] src_idx;
  logic             issue;
  logic             rd_write;
  logic [LAT_W:0]   lat_ext;
  logic [LAT_W-1:0] lat_sat;

  assign branch = wb_bju_upd_mis_i | wb_excp_br_tkn_i;

  // Any valid non-x0 source whose producer is still counting down blocks ID.
  always_comb begin
    src_hit = 1'b0;
    src_idx = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_idx = id_rs_idx_i[s*IDX_W +: IDX_W];
      if (id_rs_vld_i[s] && (src_idx != '0) && (cnt_q[src_idx] != '0)) begin
        src_hit = 1'b1;
      end
    end
  end

  assign hazard   = id_vld_i & src_hit;
  assign issue    = id_vld_i & ~branch & ~mdu_busy_i & ~hazard;
  assign rd_write = issue & id_rd_vld_i & (id_rd_idx_i != '0);

  // The extra bit keeps the clamp comparison meaningful at any MAX_LAT.
  assign lat_ext = {1'b0, id_rd_lat_i};
  assign lat_sat = (lat_ext > (LAT_W + 1)'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_rd_lat_i;

  // Pipe-register controls, prioritised flush over MDU busy over hazard.
  always_comb begin
    pcu_clear_if_id_o = 1'b0;
    pcu_clear_id_ex_o = 1'b0;
    pcu_clear_ex_wb_o = 1'b0;
    pcu_stall_pc_o    = 1'b0;
    pcu_stall_if_id_o = 1'b0;
    pcu_stall_id_ex_o = 1'b0;
    if (branch) begin
      pcu_clear_if_id_o = 1'b1;
      pcu_clear_id_ex_o = 1'b1;
      pcu_clear_ex_wb_o = 1'b1;
    end else if (mdu_busy_i) begin
      pcu_stall_pc_o    = 1'b1;
      pcu_stall_if_id_o = 1'b1;
      pcu_stall_id_ex_o = 1'b1;
      pcu_clear_ex_wb_o = 1'b1;
    end else if (hazard) begin
      // Stall and clear both set on ID/EX; the pipe register lets clear win.
      pcu_stall_pc_o    = 1'b1;
      pcu_stall_if_id_o = 1'b1;
      pcu_stall_id_ex_o = 1'b1;
      pcu_clear_id_ex_o = 1'b1;
    end
  end

  assign pcu_clear_pc_o    = 1'b0;
  assign pcu_stall_ex_wb_o = 1'b0;
  assign pcu_issue_o       = issue;
  assign pcu_stall_cnt_o   = stall_cnt_q;

  // Scoreboard countdown: decrement, reload on issue, wipe on flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (branch) begin
          cnt_q[r] <= '0;
        end else if (rd_write && (id_rd_idx_i == IDX_W'(r))) begin
          cnt_q[r] <= lat_sat;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - 1'b1;
        end
      end
    end
  end

  // Saturating count of cycles lost to hazard or MDU stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if ((hazard | mdu_busy_i) & ~branch & (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule
